mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Shares a WIDTH-bit 4:1 output path among four requesters. Picks one pending
//   requester (round-robin or fixed priority), drives the 4:1 select, captures the
//   winner's word into a registered output and holds it under a valid/ready
//   handshake. Sits between four producer ports and a single downstream consumer.
// PARAMETERS
//   WIDTH      3   data width of D0..D3 and Y
//   PRIO_MODE  0   0 = round-robin starting after last winner; 1 = fixed, D0 highest
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   4      req[i]=1: requester i has a word on Di
//   D0..D3     in   WIDTH  requester data words
//   out_ready  in   1      consumer can accept Y this cycle
//   sel        out  2      select of the granted requester (registered)
//   gnt        out  4      one-hot grant, held for the whole transfer (registered)
//   Y          out  WIDTH  captured word, equals D[sel] at capture edge (registered)
//   out_valid  out  1      Y holds an unconsumed word
//   ack        out  4      one-hot, comb: out_valid & out_ready & gnt; word i consumed
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, sel=0, gnt=0, Y=0, out_valid=0, ack=0,
//     rr pointer last=2'd3 so the first round-robin search starts at requester 0.
//   FSM IDLE:
//     - req==0: stay IDLE, outputs hold, out_valid=0.
//     - req!=0: winner w chosen combinationally; on the edge: sel<=w, gnt<=1<<w,
//       Y<=Dw, out_valid<=1, last<=w, state<=BUSY.
//     - RR order: last+1, last+2, last+3, last+4 (mod 4); first set req wins.
//     - PRIO_MODE=1: lowest set index wins, last is still updated but ignored.
//   FSM BUSY:
//     - out_valid=1; Y, sel, gnt stable; D inputs and req ignored.
//     - out_ready=0: stay BUSY (no timeout).
//     - out_ready=1: ack[w]=1 this cycle; edge: out_valid<=0, gnt<=0, state<=IDLE.
//       sel and Y keep last values.
//   Latency: req seen in IDLE -> out_valid on next edge (1 cycle). Minimum 2 cycles
//     per word (IDLE+BUSY); back-to-back max throughput 1 word / 2 cycles.
//   Requester rule: req[i] is sampled only in IDLE. A requester with no more
//     words drops req on the edge where it sees ack[i]. Since IDLE follows, its
//     stale req is never re-granted. A requester holding req gets another word.
//   Fairness (RR): with all four req high, grants cycle 0,1,2,3,0,...; no
//     requester waits more than 3 transfers.
//   Simultaneous events: req changes during BUSY have no effect. ack and new
//     arbitration never share a cycle.
//   Reset mid-transfer: out_valid, gnt drop immediately (async); no ack issued,
//     word lost; pointer returns to 3.
//   Captured Y is exactly Dw bit-for-bit; no width conversion.
// TESTING  (A=3'b001 on D0, B=3'b010 on D1, C=3'b101 on D2, D=3'b110 on D3)
//   1 Reset: rst_n=0 mid-sim -> same cycle out_valid=0, gnt=0, Y=0, sel=0, ack=0.
//   2 Single: req=4'b0100, out_ready=1 -> next edge sel=2, gnt=0100, Y=101,
//     out_valid=1, ack=0100 that cycle; idle after req drop.
//   3 RR fairness: req=4'b1111 held, out_ready=1 -> sel seq 0,1,2,3,0;
//     Y seq 001,010,101,110,001; one word every 2 cycles.
//   4 Backpressure: req=4'b0010, out_ready=0 for 5 cycles -> Y=010, sel=1 stable,
//     ack=0; out_ready=1 -> ack=0010 for exactly 1 cycle, then out_valid=0.
//   5 Masking: grant to 0 then req=4'b1011 -> next winner 1, then 3, skipping 2.
//     With PRIO_MODE=1 and req=4'b1011 held -> always 0.
//   6 Abort: assert rst_n=0 while BUSY with gnt=1000 -> no ack. After release,
//     req=4'b1001 -> first winner is 0 (pointer reset).

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
//   Bundles the four-requester side and the single consumer side of the
//   mux4_rr_arbiter data path.
//
//   req        4      per-requester "word pending" flags
//   d0..d3     WIDTH  requester data words
//   out_ready  1      consumer can take y this cycle
//   sel        2      select of the granted requester
//   gnt        4      one-hot grant, held across the transfer
//   y          WIDTH  captured word
//   out_valid  1      y holds an unconsumed word
//   ack        4      one-hot, word of requester i consumed this cycle
//
//   master : producers/consumer side (drives req, d*, out_ready)
//   slave  : arbiter side (drives sel, gnt, y, out_valid, ack)
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 3
);
    logic [3:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic [3:0]       ack;

    modport master (
        output req, d0, d1, d2, d3, out_ready,
        input  sel, gnt, y, out_valid, ack
    );

    modport slave (
        input  req, d0, d1, d2, d3, out_ready,
        output sel, gnt, y, out_valid, ack
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Shares one WIDTH-bit output among four requesters. In IDLE a winner is
//   picked (round-robin after the last winner, or fixed priority with
//   requester 0 highest), its word is captured into y and held under a
//   valid/ready handshake in BUSY until the consumer takes it.
//
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mux4_rr_arbiter_if (req, d0..d3, out_ready in;
//          sel, gnt, y, out_valid, ack out)
//
//   state | meaning
//   IDLE  | no word held; arbitrate among pending requesters
//   BUSY  | word held in y, waiting for out_ready; req and d ignored
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int WIDTH     = 3,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_last;
    logic [1:0]       r_sel;
    logic [3:0]       r_gnt;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    logic [1:0]       w_win;
    logic             w_hit;
    logic [1:0]       w_idx;
    logic [WIDTH-1:0] w_dsel;
    logic             w_any;

    assign w_any = |bus.req;

    // Round-robin scans last+1 .. last+4; the 2-bit add wraps mod 4, so the
    // fourth step lands on last itself (re-grant if it is the only one).
    always_comb begin
        w_win = 2'd0;
        w_hit = 1'b0;
        w_idx = 2'd0;
        if (PRIO_MODE == 1) begin
            for (int k = 3; k >= 0; k--) begin
                if (bus.req[k]) begin
                    w_win = 2'(k);
                end
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                w_idx = r_last + 2'(k);
                if (!w_hit && bus.req[w_idx]) begin
                    w_win = w_idx;
                    w_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (w_win)
            2'd0:    w_dsel = bus.d0;
            2'd1:    w_dsel = bus.d1;
            2'd2:    w_dsel = bus.d2;
            default: w_dsel = bus.d3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_sel   <= 2'd0;
            r_gnt   <= 4'd0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_y     <= w_dsel;
                        r_valid <= 1'b1;
                        r_last  <= w_win;
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    // sel and y deliberately keep their values after the hand-off
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_gnt   <= 4'd0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.gnt       = r_gnt;
    assign bus.y         = r_y;
    assign bus.out_valid = r_valid;
    assign bus.ack       = r_gnt & {4{r_valid & bus.out_ready}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   tb_req = 4'd0;
    logic         tb_rdy = 1'b0;
    logic [W-1:0] tb_d [4];

    mux4_rr_arbiter_if #(.WIDTH(W)) bus_rr ();
    mux4_rr_arbiter_if #(.WIDTH(W)) bus_fx ();

    assign bus_rr.req = tb_req;  assign bus_fx.req = tb_req;
    assign bus_rr.d0  = tb_d[0]; assign bus_fx.d0  = tb_d[0];
    assign bus_rr.d1  = tb_d[1]; assign bus_fx.d1  = tb_d[1];
    assign bus_rr.d2  = tb_d[2]; assign bus_fx.d2  = tb_d[2];
    assign bus_rr.d3  = tb_d[3]; assign bus_fx.d3  = tb_d[3];
    assign bus_rr.out_ready = tb_rdy;
    assign bus_fx.out_ready = tb_rdy;

    mux4_rr_arbiter #(.WIDTH(W), .PRIO_MODE(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    mux4_rr_arbiter #(.WIDTH(W), .PRIO_MODE(1)) u_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx));

    // observed {sel, gnt, y, out_valid}; index 0 = round-robin, 1 = fixed
    logic [9:0] obs_out [2];
    logic [3:0] obs_ack [2];
    assign obs_out[0] = {bus_rr.sel, bus_rr.gnt, bus_rr.y, bus_rr.out_valid};
    assign obs_out[1] = {bus_fx.sel, bus_fx.gnt, bus_fx.y, bus_fx.out_valid};
    assign obs_ack[0] = bus_rr.ack;
    assign obs_ack[1] = bus_fx.ack;

    // reference model: a transfer slot per instance
    bit           m_busy [2];
    int           m_win  [2];
    int           m_last [2];
    logic [W-1:0] m_y    [2];

    logic [3:0] pre_ack [2];
    logic [3:0] pre_exp [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [9:0] exp_out(int i);
        logic [3:0] g;
        g = m_busy[i] ? (4'b0001 << m_win[i]) : 4'b0000;
        return {2'(m_win[i]), g, m_y[i], m_busy[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_win[i]  = 0;
            m_last[i] = 3;
            m_y[i]    = '0;
        end
    endtask

    task automatic model_edge(int i);
        int w;
        if (m_busy[i]) begin
            if (tb_rdy) m_busy[i] = 1'b0;
        end else if (tb_req != 4'd0) begin
            w = -1;
            if (i == 1) begin
                for (int k = 0; k < 4; k++)
                    if (w < 0 && tb_req[k]) w = k;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int idx;
                    idx = (m_last[i] + k) % 4;
                    if (w < 0 && tb_req[idx]) w = idx;
                end
            end
            m_win[i]  = w;
            m_last[i] = w;
            m_y[i]    = tb_d[w];
            m_busy[i] = 1'b1;
        end
    endtask

    task automatic set_abcd();
        tb_d[0] = 3'b001;
        tb_d[1] = 3'b010;
        tb_d[2] = 3'b101;
        tb_d[3] = 3'b110;
    endtask

    // One clock: drive at negedge, record comb ack before the edge, advance
    // the model on the edge, return at the following negedge.
    task automatic cycle(input logic [3:0] rq, input logic rdy, input bit rnd);
        tb_req = rq;
        tb_rdy = rdy;
        if (rnd) for (int j = 0; j < 4; j++) tb_d[j] = W'($urandom);
        #1;
        for (int i = 0; i < 2; i++) begin
            pre_ack[i] = obs_ack[i];
            pre_exp[i] = (m_busy[i] && rdy) ? (4'b0001 << m_win[i]) : 4'b0000;
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        tb_req = 4'd0;
        tb_rdy = 1'b0;
        rst_n  = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        set_abcd();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_out[i] !== 10'd0 || obs_ack[i] !== 4'd0) begin
                n_errors++;
                $display("FAIL reset_init dut%0d: got out=%h ack=%b expected out=000 ack=0000", i, obs_out[i], obs_ack[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1111, 1'b0, 1'b0);
        #2;
        tb_rdy = 1'b1;
        rst_n  = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_out[i] !== 10'd0 || obs_ack[i] !== 4'd0) begin
                n_errors++;
                $display("FAIL reset_mid dut%0d: got out=%h ack=%b expected out=000 ack=0000", i, obs_out[i], obs_ack[i]);
            end
        end
        model_reset();
        tb_req = 4'd0;
        tb_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_abcd();
        cycle(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_out[i] !== {2'd2, 4'b0100, 3'b101, 1'b1}) begin
                n_errors++;
                $display("FAIL single_capture dut%0d: got %h expected %h", i, obs_out[i], {2'd2, 4'b0100, 3'b101, 1'b1});
            end
        end
        cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (pre_ack[i] !== 4'b0100 || obs_out[i] !== {2'd2, 4'b0000, 3'b101, 1'b0}) begin
                n_errors++;
                $display("FAIL single_ack dut%0d: got ack=%b out=%h expected ack=0100 out=%h", i, pre_ack[i], obs_out[i], {2'd2, 4'b0000, 3'b101, 1'b0});
            end
        end
        cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (pre_ack[i] !== 4'd0 || obs_out[i] !== exp_out(i)) begin
                n_errors++;
                $display("FAIL single_idle dut%0d: got ack=%b out=%h expected ack=0000 out=%h", i, pre_ack[i], obs_out[i], exp_out(i));
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [1:0]   sel_seq [5];
        logic [W-1:0] y_seq   [5];
        sel_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        y_seq   = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b001};
        pulse_reset();
        set_abcd();
        for (int n = 0; n < 5; n++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            n_checks++;
            if (bus_rr.sel !== sel_seq[n] || bus_rr.y !== y_seq[n] || bus_rr.out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_seq word%0d: got sel=%0d y=%b valid=%b expected sel=%0d y=%b valid=1", n, bus_rr.sel, bus_rr.y, bus_rr.out_valid, sel_seq[n], y_seq[n]);
            end
            n_checks++;
            if (bus_fx.sel !== 2'd0 || bus_fx.y !== 3'b001) begin
                n_errors++;
                $display("FAIL fixed_seq word%0d: got sel=%0d y=%b expected sel=0 y=001", n, bus_fx.sel, bus_fx.y);
            end
            cycle(4'b1111, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (pre_ack[i] !== pre_exp[i] || obs_out[i] !== exp_out(i)) begin
                    n_errors++;
                    $display("FAIL rr_ack dut%0d word%0d: got ack=%b out=%h expected ack=%b out=%h", i, n, pre_ack[i], obs_out[i], pre_exp[i], exp_out(i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        set_abcd();
        cycle(4'b0010, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            cycle(4'b0010, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (pre_ack[i] !== 4'd0 || obs_out[i] !== {2'd1, 4'b0010, 3'b010, 1'b1}) begin
                    n_errors++;
                    $display("FAIL bp_hold dut%0d cyc%0d: got ack=%b out=%h expected ack=0000 out=%h", i, n, pre_ack[i], obs_out[i], {2'd1, 4'b0010, 3'b010, 1'b1});
                end
            end
        end
        cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (pre_ack[i] !== 4'b0010 || obs_out[i][0] !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_release dut%0d: got ack=%b valid=%b expected ack=0010 valid=0", i, pre_ack[i], obs_out[i][0]);
            end
        end
        cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (pre_ack[i] !== 4'd0) begin
                n_errors++;
                $display("FAIL bp_single_ack dut%0d: got ack=%b expected 0000", i, pre_ack[i]);
            end
        end
    endtask

    task automatic test_masking();
        logic [1:0] rr_seq [3];
        rr_seq = '{2'd1, 2'd3, 2'd0};
        pulse_reset();
        set_abcd();
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b1011, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            cycle(4'b1011, 1'b1, 1'b0);
            n_checks++;
            if (bus_rr.sel !== rr_seq[n] || bus_fx.sel !== 2'd0 || obs_out[0] !== exp_out(0) || obs_out[1] !== exp_out(1)) begin
                n_errors++;
                $display("FAIL mask_win%0d: got rr_sel=%0d fx_sel=%0d expected rr_sel=%0d fx_sel=0", n, bus_rr.sel, bus_fx.sel, rr_seq[n]);
            end
            cycle(4'b1011, 1'b1, 1'b0);
        end
    endtask

    task automatic test_abort();
        pulse_reset();
        set_abcd();
        cycle(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_out[i] !== {2'd3, 4'b1000, 3'b110, 1'b1}) begin
                n_errors++;
                $display("FAIL abort_setup dut%0d: got %h expected %h", i, obs_out[i], {2'd3, 4'b1000, 3'b110, 1'b1});
            end
        end
        #2;
        tb_rdy = 1'b1;
        rst_n  = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_out[i] !== 10'd0 || obs_ack[i] !== 4'd0) begin
                n_errors++;
                $display("FAIL abort_drop dut%0d: got out=%h ack=%b expected out=000 ack=0000", i, obs_out[i], obs_ack[i]);
            end
        end
        model_reset();
        tb_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1001, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_out[i] !== {2'd0, 4'b0001, 3'b001, 1'b1}) begin
                n_errors++;
                $display("FAIL abort_restart dut%0d: got %h expected %h", i, obs_out[i], {2'd0, 4'b0001, 3'b001, 1'b1});
            end
        end
        cycle(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] rq;
        logic       rdy;
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            rq  = 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rq, rdy, 1'b1);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (pre_ack[i] !== pre_exp[i] || obs_out[i] !== exp_out(i)) begin
                    n_errors++;
                    $display("FAIL random dut%0d cyc%0d: got ack=%b out=%h expected ack=%b out=%h", i, n, pre_ack[i], obs_out[i], pre_exp[i], exp_out(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_backpressure();
        test_masking();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
